// File: rtl/line_refill_ctrl.sv
// Single-line D-cache refill sequencer: critical-word-first WRAP burst on a 32-bit AXI
// read channel, store-miss byte merge, and hand-off of the assembled line to the data array.
module line_refill_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,

    input  logic                     i_miss_valid,
    output logic                     o_miss_ready,
    input  logic [ADDR_W-1:0]        i_miss_addr,
    input  logic                     i_miss_store,
    input  logic [3:0]               i_miss_wstrb,
    input  logic [31:0]              i_miss_wdata,

    output logic                     o_ar_valid,
    input  logic                     i_ar_ready,
    output logic [ADDR_W-1:0]        o_ar_addr,
    output logic [7:0]               o_ar_len,
    output logic [1:0]               o_ar_burst,

    input  logic                     i_r_valid,
    output logic                     o_r_ready,
    input  logic [31:0]              i_r_data,
    input  logic                     i_r_last,

    output logic                     o_crit_valid,
    output logic [31:0]              o_crit_data,

    output logic                     o_fill_valid,
    input  logic                     i_fill_ready,
    output logic [ADDR_W-1:0]        o_fill_addr,
    output logic [LINE_WORDS*32-1:0] o_fill_line,

    output logic                     o_proto_err,
    output logic                     o_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_AR     = 2'd1;
    localparam logic [1:0] S_RBURST = 2'd2;
    localparam logic [1:0] S_FILL   = 2'd3;

    logic [1:0]               r_state;
    logic [ADDR_W-1:2]        r_addr;
    logic                     r_store;
    logic [3:0]               r_wstrb;
    logic [31:0]              r_wdata;
    logic [2:0]               r_beat;
    logic [LINE_WORDS*32-1:0] r_line;
    logic                     r_crit_valid;
    logic [31:0]              r_crit_data;
    logic                     r_proto_err;

    logic [2:0]               w_word_idx;
    logic                     w_last_beat;
    logic [31:0]              w_beat_word;
    logic                     w_unused_addr;

    // Byte offset bits never reach the bus; all transfers are word aligned.
    assign w_unused_addr = ^i_miss_addr[1:0];

    // The 3-bit sum wraps exactly like the AXI WRAP burst over an 8-word line.
    assign w_word_idx  = r_addr[4:2] + r_beat;
    assign w_last_beat = (r_beat == 3'd7);

    // Only beat 0 carries the critical word, which is the one the pending store targets.
    always_comb begin
        w_beat_word = i_r_data;
        if (r_store && (r_beat == 3'd0)) begin
            for (int j = 0; j < 4; j++) begin
                if (r_wstrb[j]) begin
                    w_beat_word[8*j +: 8] = r_wdata[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_store      <= 1'b0;
            r_wstrb      <= '0;
            r_wdata      <= '0;
            r_beat       <= '0;
            r_line       <= '0;
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_crit_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_miss_valid) begin
                        r_addr  <= i_miss_addr[ADDR_W-1:2];
                        r_store <= i_miss_store;
                        r_wstrb <= i_miss_wstrb;
                        r_wdata <= i_miss_wdata;
                        r_beat  <= '0;
                        r_state <= S_AR;
                    end
                end
                S_AR: begin
                    if (i_ar_ready) begin
                        r_state <= S_RBURST;
                    end
                end
                S_RBURST: begin
                    if (i_r_valid) begin
                        r_line[{w_word_idx, 5'b00000} +: 32] <= w_beat_word;
                        r_beat <= r_beat + 3'd1;
                        if (r_beat == 3'd0) begin
                            r_crit_valid <= 1'b1;
                            r_crit_data  <= i_r_data;
                        end
                        // The beat count, not r_last, ends the burst; a mismatch is only flagged.
                        if (i_r_last != w_last_beat) begin
                            r_proto_err <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (i_fill_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_miss_ready = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_ar_valid   = (r_state == S_AR);
    assign o_ar_addr    = {r_addr, 2'b00};
    assign o_ar_len     = 8'd7;
    assign o_ar_burst   = 2'b10;
    assign o_r_ready    = (r_state == S_RBURST);
    assign o_crit_valid = r_crit_valid;
    assign o_crit_data  = r_crit_data;
    assign o_fill_valid = (r_state == S_FILL);
    assign o_fill_addr  = {r_addr[ADDR_W-1:5], 5'b00000};
    assign o_fill_line  = r_line;
    assign o_proto_err  = r_proto_err;

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Scoreboard bench for line_refill_ctrl: a bench-driven AXI read slave plus queues of
// expected AR addresses, critical words and filled lines, checked as the DUT emits them.
module tb_line_refill_ctrl;

    logic         clk = 1'b0;
    logic         resetn;
    logic         missValid, missReady;
    logic [31:0]  missAddr;
    logic         missStore;
    logic [3:0]   missWstrb;
    logic [31:0]  missWdata;
    logic         arValid, arReady;
    logic [31:0]  arAddr;
    logic [7:0]   arLen;
    logic [1:0]   arBurst;
    logic         rValid, rReady;
    logic [31:0]  rData;
    logic         rLast;
    logic         critValid;
    logic [31:0]  critData;
    logic         fillValid, fillReady;
    logic [31:0]  fillAddr;
    logic [255:0] fillLine;
    logic         protoErr, busy;

    int numChecks = 0;
    int numErrors = 0;

    logic [31:0]  arQ[$];
    logic [31:0]  critQ[$];
    logic [31:0]  fillAddrQ[$];
    logic [255:0] fillLineQ[$];
    logic         prevCrit = 1'b0;

    always #5 clk = ~clk;

    line_refill_ctrl #(.LINE_WORDS(8), .ADDR_W(32)) dut (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_miss_valid (missValid),
        .o_miss_ready (missReady),
        .i_miss_addr  (missAddr),
        .i_miss_store (missStore),
        .i_miss_wstrb (missWstrb),
        .i_miss_wdata (missWdata),
        .o_ar_valid   (arValid),
        .i_ar_ready   (arReady),
        .o_ar_addr    (arAddr),
        .o_ar_len     (arLen),
        .o_ar_burst   (arBurst),
        .i_r_valid    (rValid),
        .o_r_ready    (rReady),
        .i_r_data     (rData),
        .i_r_last     (rLast),
        .o_crit_valid (critValid),
        .o_crit_data  (critData),
        .o_fill_valid (fillValid),
        .i_fill_ready (fillReady),
        .o_fill_addr  (fillAddr),
        .o_fill_line  (fillLine),
        .o_proto_err  (protoErr),
        .o_busy       (busy)
    );

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Output monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (critValid === 1'b1) begin
            checkOutput("crit_pulse_len", prevCrit, 1'b0);
            if (critQ.size() > 0) checkOutput("crit_data", critData, critQ.pop_front());
            else                  checkOutput("crit_unexpected", critValid, 1'b0);
        end
        prevCrit = (critValid === 1'b1);
        if (arValid === 1'b1 && arReady === 1'b1) begin
            if (arQ.size() > 0) begin
                checkOutput("ar_addr", arAddr, arQ.pop_front());
                checkOutput("ar_len", arLen, 8'd7);
                checkOutput("ar_burst", arBurst, 2'b10);
            end else begin
                checkOutput("ar_unexpected", arValid, 1'b0);
            end
        end
        if (fillValid === 1'b1 && fillReady === 1'b1) begin
            if (fillAddrQ.size() > 0) begin
                checkOutput("fill_addr", fillAddr, fillAddrQ.pop_front());
                checkOutput("fill_line", fillLine, fillLineQ.pop_front());
            end else begin
                checkOutput("fill_unexpected", fillValid, 1'b0);
            end
        end
    end

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_miss_ready"}, missReady, 1'b1);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_ar_valid"}, arValid, 1'b0);
        checkOutput({tag, "_r_ready"}, rReady, 1'b0);
        checkOutput({tag, "_crit_valid"}, critValid, 1'b0);
        checkOutput({tag, "_fill_valid"}, fillValid, 1'b0);
        checkOutput({tag, "_proto_err"}, protoErr, 1'b0);
        checkOutput({tag, "_ar_addr"}, arAddr, 32'h0);
        checkOutput({tag, "_fill_addr"}, fillAddr, 32'h0);
        checkOutput({tag, "_fill_line"}, fillLine, 256'h0);
    endtask

    // One refill as seen from the miss path and a bench-driven AXI slave.
    task automatic applyStimulus(input logic [31:0] addr, input logic store, input logic [3:0] wstrb,
                                 input logic [31:0] wdata, input logic [31:0] base, input int arDelay,
                                 input logic [7:0] bubbleMask, input int fillDelay, input int lastIdx,
                                 input int abortBeats, input logic secondMiss, input logic [31:0] secondAddr);
        logic [255:0] expLine;
        logic [31:0]  word;
        logic [31:0]  expAr;
        logic [2:0]   idx;
        logic         ok;
        logic         done;

        expLine = '0;
        for (int k = 0; k < 8; k++) begin
            word = base + k;
            idx  = addr[4:2] + 3'(k);
            if (k == 0 && store) begin
                for (int j = 0; j < 4; j++) begin
                    if (wstrb[j]) word[8*j +: 8] = wdata[8*j +: 8];
                end
            end
            expLine[{idx, 5'b00000} +: 32] = word;
        end
        expAr = {addr[31:2], 2'b00};
        arQ.push_back(expAr);
        critQ.push_back(base);
        if (abortBeats == 0) begin
            fillAddrQ.push_back({addr[31:5], 5'b00000});
            fillLineQ.push_back(expLine);
        end

        missValid = 1'b1;
        missAddr  = addr;
        missStore = store;
        missWstrb = wstrb;
        missWdata = wdata;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            ok = missReady;
            @(posedge clk); #1;
            if (ok) break;
        end
        checkOutput("miss_accept", ok, 1'b1);
        missValid = 1'b0;

        arReady = (arDelay == 0);
        @(negedge clk);
        checkOutput("ar_latency", arValid, 1'b1);
        checkOutput("ar_busy", busy, 1'b1);
        checkOutput("ar_miss_ready", missReady, 1'b0);
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            if (arReady && arValid) begin
                @(posedge clk); #1;
                arReady = 1'b0;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (t + 1 >= arDelay) arReady = 1'b1;
                @(negedge clk);
                checkOutput("ar_hold_valid", arValid, 1'b1);
                checkOutput("ar_hold_addr", arAddr, expAr);
            end
        end
        checkOutput("ar_handshake", done, 1'b1);

        if (secondMiss) begin
            missValid = 1'b1;
            missAddr  = secondAddr;
            missStore = 1'b0;
        end

        for (int k = 0; k < 8; k++) begin
            if (bubbleMask[k]) begin
                rValid = 1'b0;
                rLast  = 1'b0;
                @(negedge clk);
                checkOutput("bubble_no_fill", fillValid, 1'b0);
                @(posedge clk); #1;
            end
            rValid = 1'b1;
            rData  = base + k;
            rLast  = (k == lastIdx);
            ok = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (t == 0) checkOutput("beat_no_fill", fillValid, 1'b0);
                ok = rReady;
                @(posedge clk); #1;
                if (ok) break;
            end
            checkOutput("r_handshake", ok, 1'b1);
            if (abortBeats != 0 && k + 1 == abortBeats) begin
                rValid    = 1'b0;
                rLast     = 1'b0;
                missValid = 1'b0;
                return;
            end
        end
        rValid = 1'b0;
        rLast  = 1'b0;

        fillReady = (fillDelay == 0);
        @(negedge clk);
        checkOutput("fill_latency", fillValid, 1'b1);
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            if (fillReady && fillValid) begin
                @(posedge clk); #1;
                fillReady = 1'b0;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (t + 1 >= fillDelay) fillReady = 1'b1;
                @(negedge clk);
                checkOutput("fill_hold_valid", fillValid, 1'b1);
                checkOutput("fill_hold_line", fillLine, expLine);
                checkOutput("fill_hold_miss_ready", missReady, 1'b0);
            end
        end
        checkOutput("fill_handshake", done, 1'b1);
        @(negedge clk);
        checkOutput("post_fill_valid", fillValid, 1'b0);
        checkOutput("post_fill_miss_ready", missReady, 1'b1);
        checkOutput("post_fill_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        resetn    = 1'b0;
        missValid = 1'b0;
        missAddr  = '0;
        missStore = 1'b0;
        missWstrb = '0;
        missWdata = '0;
        arReady   = 1'b0;
        rValid    = 1'b0;
        rData     = '0;
        rLast     = 1'b0;
        fillReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        checkOutput("reset_ar_len", arLen, 8'd7);
        checkOutput("reset_ar_burst", arBurst, 2'b10);
        @(posedge clk); #1;
        resetn = 1'b1;

        $display("[TB] load miss, offset 2, back-to-back beats");
        applyStimulus(32'h0000_1068, 1'b0, 4'b0000, 32'h0, 32'h0000_00A0, 0, 8'h00, 0, 7, 0, 1'b0, 32'h0);
        checkOutput("clean_proto_err", protoErr, 1'b0);

        $display("[TB] store miss, offset 7, partial strobes");
        applyStimulus(32'h0000_201C, 1'b1, 4'b0101, 32'h1122_3344, 32'hAABB_CCDD, 0, 8'h00, 0, 7, 0, 1'b0, 32'h0);

        $display("[TB] AR stall and R bubbles");
        applyStimulus(32'h0000_3004, 1'b0, 4'b0000, 32'h0, 32'h3000_0000, 5, 8'b0010_0100, 0, 7, 0, 1'b0, 32'h0);

        $display("[TB] fill backpressure with a second miss held");
        applyStimulus(32'h0000_4010, 1'b0, 4'b0000, 32'h0, 32'h4000_0000, 0, 8'h00, 3, 7, 0, 1'b1, 32'h0000_5008);
        applyStimulus(32'h0000_5008, 1'b1, 4'b1100, 32'hDEAD_BEEF, 32'h5000_0000, 1, 8'h00, 0, 7, 0, 1'b0, 32'h0);
        checkOutput("pre_proto_err", protoErr, 1'b0);

        $display("[TB] early r_last on beat 5");
        applyStimulus(32'h0000_6000, 1'b0, 4'b0000, 32'h0, 32'h6000_0000, 0, 8'h00, 0, 5, 0, 1'b0, 32'h0);
        checkOutput("proto_err_set", protoErr, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("proto_err_sticky", protoErr, 1'b1);

        $display("[TB] reset mid-burst");
        applyStimulus(32'h0000_7014, 1'b0, 4'b0000, 32'h0, 32'h7000_0000, 0, 8'h00, 0, 7, 3, 1'b0, 32'h0);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        checkIdle("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("abort_no_fill", fillValid, 1'b0);
        end

        $display("[TB] refill after abort");
        applyStimulus(32'h0000_8018, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h8000_0000, 2, 8'b1000_0001, 1, 7, 0, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("ar_queue_empty", arQ.size(), 0);
        checkOutput("crit_queue_empty", critQ.size(), 0);
        checkOutput("fill_queue_empty", fillAddrQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
